// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: two 2-entry source queues (execute, load) share one registered
// register-file write port. Define WB_RR_EN for round-robin; default is load-first priority.
module reg_wb_arbiter #(
  parameter int ADDR_WIDTH  = 5,
  parameter int INSTR_WIDTH = 32,
  parameter int RA          = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_WIDTH-1:0]  alu_rd,
  input  logic [INSTR_WIDTH-1:0] alu_result,
  input  logic [INSTR_WIDTH-1:0] alu_pc_out,
  input  logic                   alu_isCall,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_WIDTH-1:0]  ld_rd,
  input  logic [INSTR_WIDTH-1:0] ld_result,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]  pend_addr,
  output logic                   pend_hit
);

  localparam logic [ADDR_WIDTH-1:0] RA_ADDR = ADDR_WIDTH'(RA);

  // Handshake: a request transfers on a rising edge where valid && ready. ready depends
  // only on the queue being not full (and not in reset), never on a same-cycle pop.
  logic [ADDR_WIDTH-1:0]  alu_addr_q [2];
  logic [INSTR_WIDTH-1:0] alu_data_q [2];
  logic                   alu_wptr, alu_rptr;
  logic [1:0]             alu_count;
  logic [ADDR_WIDTH-1:0]  ld_addr_q [2];
  logic [INSTR_WIDTH-1:0] ld_data_q [2];
  logic                   ld_wptr, ld_rptr;
  logic [1:0]             ld_count;

  logic                   alu_push, ld_push;
  logic                   grant_alu, grant_ld, any_grant;
  logic [ADDR_WIDTH-1:0]  alu_in_addr, g_addr;
  logic [INSTR_WIDTH-1:0] alu_in_data, g_data;
  logic [1:0]             alu_vld, ld_vld;

  assign alu_ready = (alu_count != 2'd2) && !rst;
  assign ld_ready  = (ld_count != 2'd2) && !rst;
  assign alu_push  = alu_valid && alu_ready;
  assign ld_push   = ld_valid && ld_ready;

  // Calls are normalised here so the rest of the pipe only sees addr/data pairs.
  assign alu_in_addr = alu_isCall ? RA_ADDR : alu_rd;
  assign alu_in_data = alu_isCall ? alu_pc_out : alu_result;

`ifdef WB_RR_EN
  logic last_exec;

  assign grant_ld = (ld_count != 2'd0) && ((alu_count == 2'd0) || last_exec);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_exec <= 1'b1;
    end else if (grant_alu) begin
      last_exec <= 1'b1;
    end else if (grant_ld) begin
      last_exec <= 1'b0;
    end
  end
`else
  assign grant_ld = (ld_count != 2'd0);
`endif

  assign grant_alu = (alu_count != 2'd0) && !grant_ld;
  assign any_grant = grant_alu || grant_ld;
  assign g_addr    = grant_ld ? ld_addr_q[ld_rptr] : alu_addr_q[alu_rptr];
  assign g_data    = grant_ld ? ld_data_q[ld_rptr] : alu_data_q[alu_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wptr  <= 1'b0;
      alu_rptr  <= 1'b0;
      alu_count <= 2'd0;
    end else begin
      if (alu_push) begin
        alu_addr_q[alu_wptr] <= alu_in_addr;
        alu_data_q[alu_wptr] <= alu_in_data;
        alu_wptr             <= ~alu_wptr;
      end
      if (grant_alu) begin
        alu_rptr <= ~alu_rptr;
      end
      case ({alu_push, grant_alu})
        2'b10:   alu_count <= alu_count + 2'd1;
        2'b01:   alu_count <= alu_count - 2'd1;
        default: alu_count <= alu_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_wptr  <= 1'b0;
      ld_rptr  <= 1'b0;
      ld_count <= 2'd0;
    end else begin
      if (ld_push) begin
        ld_addr_q[ld_wptr] <= ld_rd;
        ld_data_q[ld_wptr] <= ld_result;
        ld_wptr            <= ~ld_wptr;
      end
      if (grant_ld) begin
        ld_rptr <= ~ld_rptr;
      end
      case ({ld_push, grant_ld})
        2'b10:   ld_count <= ld_count + 2'd1;
        2'b01:   ld_count <= ld_count - 2'd1;
        default: ld_count <= ld_count;
      endcase
    end
  end

  // x0 entries are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (any_grant && (g_addr != '0)) begin
      wr_en   <= 1'b1;
      wr_addr <= g_addr;
      wr_data <= g_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_comb begin
    alu_vld = 2'b00;
    ld_vld  = 2'b00;
    if (alu_count == 2'd2) alu_vld = 2'b11;
    else if (alu_count == 2'd1) alu_vld[alu_rptr] = 1'b1;
    if (ld_count == 2'd2) ld_vld = 2'b11;
    else if (ld_count == 2'd1) ld_vld[ld_rptr] = 1'b1;
  end

  always_comb begin
    pend_hit = 1'b0;
    if (!rst && (pend_addr != '0)) begin
      for (int i = 0; i < 2; i++) begin
        if (alu_vld[i] && (alu_addr_q[i] == pend_addr)) pend_hit = 1'b1;
        if (ld_vld[i] && (ld_addr_q[i] == pend_addr)) pend_hit = 1'b1;
      end
      if (wr_en && (wr_addr == pend_addr)) pend_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: a queue-level reference model predicts each register write,
// ready level and pend_hit; a negedge monitor compares the DUT against those predictions.
module tb_reg_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RA = 1;
  localparam int W  = 32 + AW + DW;

  logic          clk;
  logic          rst;
  logic          alu_valid, alu_ready, alu_isCall;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_result, alu_pc_out;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_result;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] pend_addr;
  logic          pend_hit;

  reg_wb_arbiter #(.ADDR_WIDTH(AW), .INSTR_WIDTH(DW), .RA(RA)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_result(alu_result), .alu_pc_out(alu_pc_out), .alu_isCall(alu_isCall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_result(ld_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_addr(pend_addr), .pend_hit(pend_hit)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t         q_alu[$];
  ent_t         q_ld[$];
  logic [W-1:0] exp_q[$];
  int           cyc;
  bit           m_last_exec;
  bit           m_wr_en;
  logic [AW-1:0] m_wr_addr;
  int           n_cmp;
  int           n_fail;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each source is a bounded FIFO of at most two writes; one write
  // per edge leaves through the arbiter and appears on the port right after that edge.
  initial begin
    int   a_sz, l_sz;
    bit   take_ld, take_alu;
    ent_t e;
    cyc = 0;
    m_last_exec = 1'b1;
    m_wr_en = 1'b0;
    m_wr_addr = '0;
    forever begin
      @(posedge clk);
      cyc++;
      a_sz = q_alu.size();
      l_sz = q_ld.size();
      if (rst) begin
        q_alu.delete();
        q_ld.delete();
        m_last_exec = 1'b1;
        m_wr_en = 1'b0;
        m_wr_addr = '0;
      end else begin
        take_ld  = 1'b0;
        take_alu = 1'b0;
`ifdef WB_RR_EN
        if (l_sz > 0 && a_sz > 0) begin
          if (m_last_exec) take_ld = 1'b1;
          else take_alu = 1'b1;
        end else begin
          take_ld  = (l_sz > 0);
          take_alu = (a_sz > 0);
        end
`else
        take_ld  = (l_sz > 0);
        take_alu = (l_sz == 0) && (a_sz > 0);
`endif
        m_wr_en = 1'b0;
        if (take_ld || take_alu) begin
          e = take_ld ? q_ld.pop_front() : q_alu.pop_front();
          m_last_exec = take_alu;
          if (e.addr != '0) begin
            m_wr_en = 1'b1;
            m_wr_addr = e.addr;
            exp_q.push_back({cyc[31:0], e.addr, e.data});
          end
        end
        if (alu_valid && a_sz < 2)
          q_alu.push_back(alu_isCall ? ent_t'{AW'(RA), alu_pc_out} : ent_t'{alu_rd, alu_result});
        if (ld_valid && l_sz < 2)
          q_ld.push_back(ent_t'{ld_rd, ld_result});
      end
    end
  end

  // Monitor: compares the port state between edges against the model.
  initial begin
    logic [W-1:0] h;
    bit           exp_hit, exp_pend;
    forever begin
      @(negedge clk);
      exp_hit = (exp_q.size() > 0) && (exp_q[0][W-1:AW+DW] == cyc[31:0]);
      check("wr_en", {31'b0, wr_en}, {31'b0, exp_hit});
      if (exp_hit) begin
        h = exp_q.pop_front();
        if (wr_en === 1'b1) begin
          check("wr_addr", {{(DW-AW){1'b0}}, wr_addr}, {{(DW-AW){1'b0}}, h[AW+DW-1:DW]});
          check("wr_data", wr_data, h[DW-1:0]);
        end
      end
      check("alu_ready", {31'b0, alu_ready}, {31'b0, (!rst && q_alu.size() < 2)});
      check("ld_ready", {31'b0, ld_ready}, {31'b0, (!rst && q_ld.size() < 2)});
      exp_pend = 1'b0;
      if (!rst && pend_addr != '0) begin
        foreach (q_alu[i]) if (q_alu[i].addr == pend_addr) exp_pend = 1'b1;
        foreach (q_ld[i]) if (q_ld[i].addr == pend_addr) exp_pend = 1'b1;
        if (m_wr_en && m_wr_addr == pend_addr) exp_pend = 1'b1;
      end
      check("pend_hit", {31'b0, pend_hit}, {31'b0, exp_pend});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    alu_isCall = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_isCall = 1'b0; alu_rd = '0; alu_result = '0; alu_pc_out = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_result = '0; pend_addr = '0;
    repeat (3) step();
    @(negedge clk);
    check("reset_wr_addr", {{(DW-AW){1'b0}}, wr_addr}, '0);
    check("reset_wr_data", wr_data, '0);
    step();
    rst = 1'b0;
    step();

    // single execute write, watching rd 5
    pend_addr = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
    step();
    idle(4);

    // call writes the link register
    pend_addr = 5'd1;
    alu_valid = 1'b1; alu_isCall = 1'b1; alu_rd = 5'd7; alu_pc_out = 32'h100; alu_result = 32'h777;
    step();
    idle(4);

    // x0 load is consumed silently
    pend_addr = 5'd0;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_result = 32'h55;
    step();
    idle(4);

    // sustained contention, both sources every cycle
    pend_addr = 5'd2;
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'hA000 + i;
      ld_valid = 1'b1; ld_rd = 5'd3; ld_result = 32'hB000 + i;
      step();
    end
    idle(8);

    // three execute requests while loads keep arriving
    for (int i = 0; i < 6; i++) begin
      alu_valid = (i < 3); alu_rd = 5'(8 + i); alu_result = 32'hC000 + i;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_result = 32'hD000 + i;
      step();
    end
    idle(8);

    // fill both queues, then reset mid-flight
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'hE000 + i;
      ld_valid = 1'b1; ld_rd = 5'd10; ld_result = 32'hF000 + i;
      step();
    end
    pend_addr = 5'd9;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(5);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      alu_valid  = ($urandom_range(0, 1) == 1);
      alu_isCall = ($urandom_range(0, 4) == 0);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_result = $urandom;
      alu_pc_out = $urandom;
      ld_valid   = ($urandom_range(0, 2) != 0);
      ld_rd      = 5'($urandom_range(0, 7));
      ld_result  = $urandom;
      pend_addr  = 5'($urandom_range(0, 7));
      rst        = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;
    idle(8);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
